// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity column).
package imem_pkg;

    // Responder sequencing: wait for a fetch, read the RAM, present the word.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } imem_state_t;

    // Instruction value returned alongside any fetch fault.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // A fetch address faults when it is not word aligned or when any bit
    // above the word-index field is set. The index never wraps.
    function automatic logic addr_fault(input logic [31:0] addr,
                                        input int unsigned depth_log2);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = ((addr >> (depth_log2 + 2)) != 32'd0);
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one write port, one registered read port.
// With IMEM_PARITY_EN defined, an even-parity bit is kept per word and
// checked against the word read back.
module imem_ram
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [31:0]           rd_data,
    output logic                  rd_par_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] mem [DEPTH];

    // Write and read in the same edge; non-blocking semantics make a
    // colliding read return the word as it was before this write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];
    logic rd_par;

    // Parity column tracks the data column with the same read-before-write timing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_mem[wr_addr] <= ^wr_data;
        end
        if (rd_en) begin
            rd_par <= par_mem[rd_addr];
        end
    end

    assign rd_par_err = (rd_par != (^rd_data));
`else
    assign rd_par_err = 1'b0;
`endif

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts one fetch at a time, reads the word
// from imem_ram and holds the response until the requester takes it.
// Program loading has priority over fetch acceptance and is allowed in
// every state. Optional macro: IMEM_PARITY_EN adds parity fault reporting.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_instr,
    output logic                  rsp_err,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);

    imem_state_t           state;
    logic [31:0]           addr_q;
    logic                  fault_q;
    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [31:0]           rd_data;
    logic                  rd_par_err;

    assign req_ready = (state == IDLE) && !load_en;
    assign rd_en     = (state == READ);
    assign rd_addr   = addr_q[DEPTH_LOG2+1:2];

    // Fetch sequencing; a reset in any state abandons the transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= 32'd0;
            fault_q   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid && req_ready) begin
                        addr_q  <= req_addr;
                        fault_q <= addr_fault(req_addr, DEPTH_LOG2);
                        state   <= READ;
                    end
                end
                READ: begin
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    imem_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .wr_en     (load_en),
        .wr_addr   (load_addr),
        .wr_data   (load_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_par_err(rd_par_err)
    );

    // The read register only moves in READ, so the response stays stable
    // for as long as RESP is held; faults replace the word with a NOP.
    assign rsp_err   = rsp_valid && (fault_q || rd_par_err);
    assign rsp_instr = (rsp_valid && !rsp_err) ? rd_data : NOP_INSTR;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder against a word-array reference model.
// Build with IMEM_PARITY_EN defined to also exercise the parity fault path.
module tb_imem_responder;

    localparam int unsigned DEPTH_LOG2 = 8;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

    logic                  clk;
    logic                  reset;
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_instr;
    logic                  rsp_err;
    logic                  load_en;
    logic [DEPTH_LOG2-1:0] load_addr;
    logic [31:0]           load_data;

    logic [31:0] mem_model [DEPTH];
    bit          par_bad   [DEPTH];
    int          checks;
    int          errors;

    imem_responder #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_err  (rsp_err),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference fault rule written from the address arithmetic directly.
    function automatic bit model_fault(input logic [31:0] addr);
        if ((addr % 4) != 0) return 1'b1;
        if (addr >= 4 * DEPTH) return 1'b1;
        return par_bad[addr / 4];
    endfunction

    task automatic load_word(input int idx, input logic [31:0] val);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = DEPTH_LOG2'(idx);
        load_data = val;
        @(negedge clk);
        load_en        = 1'b0;
        mem_model[idx] = val;
        par_bad[idx]   = 1'b0;
    endtask

    // One fetch. load_mode: 0 none, 1 load while requesting in IDLE,
    // 2 load during the READ cycle.
    task automatic applyStimulus(input logic [31:0] addr, input int hold,
                                 input int load_mode, input int ld_idx,
                                 input logic [31:0] ld_val);
        logic [31:0] exp_instr;
        bit          exp_err;
        bit          accepted;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = 1'b0;
        if (load_mode == 1) begin
            load_en   = 1'b1;
            load_addr = DEPTH_LOG2'(ld_idx);
            load_data = ld_val;
            #1;
            checkOutput("req_ready_while_loading", 32'(req_ready), 32'd0);
            @(negedge clk);
            load_en           = 1'b0;
            mem_model[ld_idx] = ld_val;
            par_bad[ld_idx]   = 1'b0;
        end
        #1;
        accepted = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!accepted) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        exp_err   = model_fault(addr);
        exp_instr = exp_err ? 32'd0 : mem_model[addr / 4];

        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("read_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("read_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("read_req_ready", 32'(req_ready), 32'd0);
        if (load_mode == 2) begin
            load_en   = 1'b1;
            load_addr = DEPTH_LOG2'(ld_idx);
            load_data = ld_val;
        end

        @(negedge clk);
        if (load_mode == 2) begin
            load_en           = 1'b0;
            mem_model[ld_idx] = ld_val;
            par_bad[ld_idx]   = 1'b0;
        end
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_instr", rsp_instr, exp_instr);
        checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_rsp_instr", rsp_instr, exp_instr);
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checkOutput("done_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("done_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] addr;
        int          kind;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        rsp_ready = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_model[i] = 32'd0;
            par_bad[i]   = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_instr", rsp_instr, 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 32; i++) load_word(i, $urandom);
        load_word(3, 32'h2108_0005);

        $display("[TB] directed fetches");
        applyStimulus(32'h0000_000C, 0, 0, 0, 32'd0);
        applyStimulus(32'h0000_0006, 0, 0, 0, 32'd0);
        applyStimulus(32'h0000_0400, 0, 0, 0, 32'd0);
        applyStimulus(32'h0000_000C, 5, 0, 0, 32'd0);
        applyStimulus(32'h0000_000C, 0, 1, 10, 32'hA5A5_0F0F);
        applyStimulus(32'h0000_0028, 0, 0, 0, 32'd0);
        applyStimulus(32'h0000_000C, 0, 2, 3, 32'hFFFF_FFFF);
        applyStimulus(32'h0000_000C, 0, 0, 0, 32'd0);

        $display("[TB] reset during response");
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_000C;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("post_reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("post_reset_rsp_instr", rsp_instr, 32'd0);
        @(negedge clk);
        checkOutput("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
        applyStimulus(32'h0000_000C, 0, 0, 0, 32'd0);

`ifdef IMEM_PARITY_EN
        $display("[TB] parity fault");
        @(negedge clk);
        dut.u_ram.par_mem[5] = ~dut.u_ram.par_mem[5];
        par_bad[5] = 1'b1;
        applyStimulus(32'h0000_0014, 0, 0, 0, 32'd0);
        load_word(5, 32'h1357_9BDF);
        applyStimulus(32'h0000_0014, 0, 0, 0, 32'd0);
`endif

        $display("[TB] randomized fetches");
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 5));
            addr = 32'($urandom_range(0, 31)) * 4;
            if (kind == 3) begin
                addr = addr | 32'($urandom_range(1, 3));
            end else if (kind == 4) begin
                addr = $urandom | (32'd1 << $urandom_range(10, 31));
            end
            applyStimulus(addr, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 31)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
